// File: rtl/ntt_pkg.sv
// Shared types for the NTT stream adapter: coefficient type, FSM states,
// and the lane-index bit-reversal helper.
package ntt_pkg;

    localparam int unsigned COEF_W = 32;

    typedef logic [COEF_W-1:0] coef_t;

    typedef enum logic [1:0] {
        FILL,
        LAUNCH,
        WAIT,
        DRAIN
    } state_t;

    function automatic int unsigned bitrev(
        input int unsigned idx,
        input int unsigned bits
    );
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < bits; i++) begin
            r = r | (((idx >> i) & 32'd1) << (bits - 1 - i));
        end
        return r;
    endfunction

endpackage

// File: rtl/ntt_beat_gearbox.sv
// Selects one stream beat worth of lanes out of a full frame.
// Beat b carries lanes [b*WORDS_PER_BEAT +: WORDS_PER_BEAT].
module ntt_beat_gearbox
    import ntt_pkg::*;
#(
    parameter int DATA_WIDTH_PER_INPUT = 32,
    parameter int INPUT_PER_CYCLE      = 32,
    parameter int WORDS_PER_BEAT       = 1,
    parameter int BEAT_CNT_W           = 5
) (
    input  logic [INPUT_PER_CYCLE*DATA_WIDTH_PER_INPUT-1:0] frame,
    input  logic [BEAT_CNT_W-1:0]                           beat,
    output logic [WORDS_PER_BEAT*DATA_WIDTH_PER_INPUT-1:0]  data
);

    localparam int BEATS  = INPUT_PER_CYCLE / WORDS_PER_BEAT;
    localparam int BEAT_W = WORDS_PER_BEAT * DATA_WIDTH_PER_INPUT;

    always_comb begin
        data = '0;
        for (int b = 0; b < BEATS; b++) begin
            if (beat == BEAT_CNT_W'(b)) begin
                data = frame[b*BEAT_W +: BEAT_W];
            end
        end
    end

endmodule

// File: rtl/ntt_stream_adapter.sv
// Packs a beat stream into full NTT core frames and unpacks the results.
// Define NTT_STREAM_BITREV_EN to emit result lanes in bit-reversed order.
module ntt_stream_adapter
    import ntt_pkg::*;
#(
    parameter int DATA_WIDTH_PER_INPUT = 32,
    parameter int INPUT_PER_CYCLE      = 32,
    parameter int WORDS_PER_BEAT       = 1,
    parameter int CORE_LATENCY         = 16
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            in_valid,
    output logic                                            in_ready,
    input  logic [WORDS_PER_BEAT*DATA_WIDTH_PER_INPUT-1:0]  in_data,
    output logic                                            out_valid,
    input  logic                                            out_ready,
    output logic [WORDS_PER_BEAT*DATA_WIDTH_PER_INPUT-1:0]  out_data,
    output logic                                            out_last,
    output logic                                            core_in_valid,
    output logic [INPUT_PER_CYCLE*DATA_WIDTH_PER_INPUT-1:0] core_in_data,
    input  logic [INPUT_PER_CYCLE*DATA_WIDTH_PER_INPUT-1:0] core_out_data
);

    localparam int W      = DATA_WIDTH_PER_INPUT;
    localparam int BEATS  = INPUT_PER_CYCLE / WORDS_PER_BEAT;
    localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CW     = (CORE_LATENCY > 1) ? $clog2(CORE_LATENCY) : 1;
    localparam int FW     = INPUT_PER_CYCLE * W;
    localparam int BEAT_W = WORDS_PER_BEAT * W;

    state_t          state;
    state_t          state_nxt;
    logic [BW-1:0]   beat_cnt;
    logic [CW-1:0]   wait_cnt;
    logic [FW-1:0]   frame_q;
    logic [FW-1:0]   result_q;
    logic [FW-1:0]   result_ord;
    logic            in_fire;
    logic            out_fire;
    logic            last_beat;
    logic            wait_done;

    assign in_ready      = (state == FILL);
    assign out_valid     = (state == DRAIN);
    assign core_in_valid = (state == LAUNCH);
    assign core_in_data  = frame_q;
    assign last_beat     = (beat_cnt == BW'(BEATS - 1));
    assign out_last      = out_valid && last_beat;
    assign in_fire       = in_valid && in_ready;
    assign out_fire      = out_valid && out_ready;
    assign wait_done     = (wait_cnt == CW'(CORE_LATENCY - 1));

`ifdef NTT_STREAM_BITREV_EN
    localparam int LW = (INPUT_PER_CYCLE > 1) ? $clog2(INPUT_PER_CYCLE) : 1;

    // Reorder once at capture so the drain path stays a plain slice mux.
    for (genvar j = 0; j < INPUT_PER_CYCLE; j++) begin : g_brev
        localparam int unsigned SRC = bitrev(j, LW);
        assign result_ord[j*W +: W] = core_out_data[SRC*W +: W];
    end
`else
    assign result_ord = core_out_data;
`endif

    always_comb begin
        state_nxt = state;
        unique case (state)
            FILL:    if (in_fire && last_beat) state_nxt = LAUNCH;
            LAUNCH:  state_nxt = WAIT;
            WAIT:    if (wait_done) state_nxt = DRAIN;
            DRAIN:   if (out_fire && last_beat) state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FILL;
            beat_cnt <= '0;
            wait_cnt <= '0;
            frame_q  <= '0;
            result_q <= '0;
        end else begin
            state <= state_nxt;
            if (in_fire) begin
                for (int b = 0; b < BEATS; b++) begin
                    if (beat_cnt == BW'(b)) begin
                        frame_q[b*BEAT_W +: BEAT_W] <= in_data;
                    end
                end
            end
            // One counter serves both the fill and the drain side.
            if (in_fire || out_fire) begin
                beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
            end
            if (state == WAIT) begin
                wait_cnt <= wait_done ? '0 : wait_cnt + 1'b1;
                if (wait_done) begin
                    result_q <= result_ord;
                end
            end
        end
    end

    ntt_beat_gearbox #(
        .DATA_WIDTH_PER_INPUT (DATA_WIDTH_PER_INPUT),
        .INPUT_PER_CYCLE      (INPUT_PER_CYCLE),
        .WORDS_PER_BEAT       (WORDS_PER_BEAT),
        .BEAT_CNT_W           (BW)
    ) u_gearbox (
        .frame (result_q),
        .beat  (beat_cnt),
        .data  (out_data)
    );

endmodule
